// File: rtl/multi_alarm.sv
// Multi-slot BCD alarm: per-slot arm bits, button editing with a blinking selected field,
// and a ring / snooze / dismiss controller with auto-timeout driven by the 1 Hz tick.
module multi_alarm #(
    parameter int NUM_ALARMS     = 4,
    parameter int IDX_W          = 2,
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_3hz,
    input  logic                  tick_1hz,
    input  logic [3:0]            btn,
    input  logic [3:0]            horas_decenas_in,
    input  logic [3:0]            horas_unidades_in,
    input  logic [3:0]            minutos_decenas_in,
    input  logic [3:0]            minutos_unidades_in,
    input  logic [3:0]            segundos_decenas_in,
    input  logic [3:0]            segundos_unidades_in,
    output logic [3:0]            horas_decenas,
    output logic [3:0]            horas_unidades,
    output logic [3:0]            minutos_decenas,
    output logic [3:0]            minutos_unidades,
    output logic [3:0]            segundos_decenas,
    output logic [3:0]            segundos_unidades,
    output logic [IDX_W-1:0]      sel_idx,
    output logic [NUM_ALARMS-1:0] armed_mask,
    output logic                  flag_alarm_armed,
    output logic                  ringing,
    output logic                  snoozing,
    output logic [IDX_W-1:0]      ring_idx
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    localparam logic [1:0]       FLD_SEC  = 2'd0;
    localparam logic [1:0]       FLD_MIN  = 2'd1;
    localparam logic [1:0]       FLD_HR   = 2'd2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ALARMS - 1);
    localparam logic [7:0]       RING_LIM = 8'(RING_SECONDS);
    localparam logic [11:0]      SNZ_LOAD = 12'(SNOOZE_MINUTES * 60);

    // BCD 00..59 increment; the carry never leaves the two-digit field.
    function automatic logic [7:0] inc_sixty(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] >= 4'd5) ? 4'd0 : (v[7:4] + 4'd1);
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    function automatic logic [7:0] inc_hours(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v == 8'h23) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    // Slot layout: [23:16] hours, [15:8] minutes, [7:0] seconds (tens in the upper nibble).
    logic [NUM_ALARMS-1:0][23:0] slot_q, slot_d;
    logic [NUM_ALARMS-1:0]       armed_q, armed_d, match_prev_q, match_s, trigger_s;
    logic [IDX_W-1:0]            sel_q, sel_d, ring_idx_q, ring_idx_d;
    logic [1:0]                  field_q, field_d;
    logic                        blink_q, blink_d;
    state_t                      state_q, state_d;
    logic [7:0]                  ring_cnt_q, ring_cnt_d;
    logic [11:0]                 snz_cnt_q, snz_cnt_d;
    logic [3:0]                  btn_s1_q, btn_s2_q, btn_s3_q, press_s;
    logic                        c3_s1_q, c3_s2_q, c3_s3_q;
    logic [23:0]                 cur_time_s, disp_q, disp_d;
    logic                        flag_q, flag_d, ringing_q, ringing_d, snoozing_q, snoozing_d;
    logic                        edit_en_s;

    assign cur_time_s = {horas_decenas_in, horas_unidades_in, minutos_decenas_in,
                         minutos_unidades_in, segundos_decenas_in, segundos_unidades_in};
    assign press_s    = btn_s3_q & ~btn_s2_q;
    assign edit_en_s  = (state_q != ST_RING);

    // Slot editing, arm toggling, field/slot selection and blink phase.
    always_comb begin
        slot_d  = slot_q;
        armed_d = armed_q;
        sel_d   = sel_q;
        field_d = field_q;
        blink_d = (c3_s2_q && !c3_s3_q) ? ~blink_q : blink_q;
        if (edit_en_s) begin
            if (press_s[0]) begin
                case (field_q)
                    FLD_SEC: slot_d[sel_q][7:0]   = inc_sixty(slot_q[sel_q][7:0]);
                    FLD_MIN: slot_d[sel_q][15:8]  = inc_sixty(slot_q[sel_q][15:8]);
                    FLD_HR:  slot_d[sel_q][23:16] = inc_hours(slot_q[sel_q][23:16]);
                    default: slot_d[sel_q]        = slot_q[sel_q];
                endcase
            end else begin
                slot_d = slot_q;
            end
            if (press_s[1]) begin
                field_d = (field_q == FLD_HR) ? FLD_SEC : (field_q + 2'd1);
            end else begin
                field_d = field_q;
            end
            if (press_s[2]) begin
                armed_d[sel_q] = ~armed_q[sel_q];
            end else begin
                armed_d = armed_q;
            end
        end else begin
            slot_d = slot_q;
        end
        if (press_s[3] && state_q == ST_IDLE) begin
            sel_d   = (sel_q == LAST_IDX) ? '0 : (sel_q + IDX_W'(1));
            field_d = FLD_SEC;
        end else begin
            sel_d = sel_q;
        end
    end

    // Per-slot match and rising-edge trigger detection.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            match_s[i] = armed_q[i] && (slot_q[i] == cur_time_s);
        end
        trigger_s = match_s & ~match_prev_q;
    end

    // Ring controller next-state logic; buttons beat the ring timeout.
    always_comb begin
        state_d    = state_q;
        ring_idx_d = ring_idx_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|trigger_s) begin
                    state_d    = ST_RING;
                    ring_cnt_d = 8'd0;
                    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
                        if (trigger_s[i]) begin
                            ring_idx_d = IDX_W'(i);
                        end else begin
                            ring_idx_d = ring_idx_d;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RING: begin
                if (press_s[0]) begin
                    state_d   = ST_SNOOZE;
                    snz_cnt_d = SNZ_LOAD;
                end else if (press_s[3]) begin
                    state_d = ST_IDLE;
                end else if (tick_1hz) begin
                    ring_cnt_d = ring_cnt_q + 8'd1;
                    state_d    = (ring_cnt_d == RING_LIM) ? ST_IDLE : ST_RING;
                end else begin
                    state_d = ST_RING;
                end
            end
            ST_SNOOZE: begin
                if (press_s[3]) begin
                    state_d = ST_IDLE;
                end else if (press_s[2] && sel_q == ring_idx_q && armed_q[ring_idx_q]) begin
                    state_d = ST_IDLE;
                end else if (tick_1hz) begin
                    snz_cnt_d = snz_cnt_q - 12'd1;
                    if (snz_cnt_d == 12'd0) begin
                        state_d    = ST_RING;
                        ring_cnt_d = 8'd0;
                    end else begin
                        state_d = ST_SNOOZE;
                    end
                end else begin
                    state_d = ST_SNOOZE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values computed from next state so the registered outputs carry no extra lag.
    always_comb begin
        ringing_d  = (state_d == ST_RING);
        snoozing_d = (state_d == ST_SNOOZE);
        flag_d     = |armed_d;
        disp_d     = slot_d[sel_d];
        if (!blink_d) begin
            case (field_d)
                FLD_SEC: disp_d[7:0]   = 8'hFF;
                FLD_MIN: disp_d[15:8]  = 8'hFF;
                FLD_HR:  disp_d[23:16] = 8'hFF;
                default: disp_d        = slot_d[sel_d];
            endcase
        end else begin
            disp_d = slot_d[sel_d];
        end
    end

    // State, datapath, synchroniser and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q       <= '0;
            armed_q      <= '0;
            match_prev_q <= '0;
            sel_q        <= '0;
            ring_idx_q   <= '0;
            field_q      <= FLD_SEC;
            blink_q      <= 1'b1;
            state_q      <= ST_IDLE;
            ring_cnt_q   <= 8'd0;
            snz_cnt_q    <= 12'd0;
            btn_s1_q     <= 4'hF;
            btn_s2_q     <= 4'hF;
            btn_s3_q     <= 4'hF;
            c3_s1_q      <= 1'b0;
            c3_s2_q      <= 1'b0;
            c3_s3_q      <= 1'b0;
            disp_q       <= 24'h000000;
            flag_q       <= 1'b0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            armed_q      <= armed_d;
            match_prev_q <= match_s;
            sel_q        <= sel_d;
            ring_idx_q   <= ring_idx_d;
            field_q      <= field_d;
            blink_q      <= blink_d;
            state_q      <= state_d;
            ring_cnt_q   <= ring_cnt_d;
            snz_cnt_q    <= snz_cnt_d;
            btn_s1_q     <= btn;
            btn_s2_q     <= btn_s1_q;
            btn_s3_q     <= btn_s2_q;
            c3_s1_q      <= clk_3hz;
            c3_s2_q      <= c3_s1_q;
            c3_s3_q      <= c3_s2_q;
            disp_q       <= disp_d;
            flag_q       <= flag_d;
            ringing_q    <= ringing_d;
            snoozing_q   <= snoozing_d;
        end
    end

    assign {horas_decenas, horas_unidades, minutos_decenas,
            minutos_unidades, segundos_decenas, segundos_unidades} = disp_q;
    assign sel_idx          = sel_q;
    assign armed_mask       = armed_q;
    assign flag_alarm_armed = flag_q;
    assign ringing          = ringing_q;
    assign snoozing         = snoozing_q;
    assign ring_idx         = ring_idx_q;

endmodule

// File: tb/tb_multi_alarm.sv
// Directed-vector bench for multi_alarm: stimulus queues expected values, a negedge monitor
// pops and compares them against the DUT outputs.
module tb_multi_alarm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clk_3hz = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [3:0] btn = 4'hF;
    logic [3:0] hd_in, hu_in, md_in, mu_in, sd_in, su_in;
    logic [3:0] hd, hu, md, mu, sd, su;
    logic [1:0] sel_idx, ring_idx;
    logic [3:0] armed_mask;
    logic       flag_alarm_armed, ringing, snoozing;

    localparam int ID_DISP = 0, ID_SEL = 1, ID_ARM = 2, ID_FLAG = 3,
                   ID_RING = 4, ID_SNZ = 5, ID_RIDX = 6;

    typedef struct {
        int          id;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    multi_alarm #(.NUM_ALARMS(4), .IDX_W(2), .RING_SECONDS(60), .SNOOZE_MINUTES(5)) dut (
        .clk(clk), .reset(reset), .clk_3hz(clk_3hz), .tick_1hz(tick_1hz), .btn(btn),
        .horas_decenas_in(hd_in), .horas_unidades_in(hu_in),
        .minutos_decenas_in(md_in), .minutos_unidades_in(mu_in),
        .segundos_decenas_in(sd_in), .segundos_unidades_in(su_in),
        .horas_decenas(hd), .horas_unidades(hu), .minutos_decenas(md),
        .minutos_unidades(mu), .segundos_decenas(sd), .segundos_unidades(su),
        .sel_idx(sel_idx), .armed_mask(armed_mask), .flag_alarm_armed(flag_alarm_armed),
        .ringing(ringing), .snoozing(snoozing), .ring_idx(ring_idx)
    );

    function automatic logic [31:0] dut_val(input int id);
        case (id)
            ID_DISP: return {8'h00, hd, hu, md, mu, sd, su};
            ID_SEL:  return {30'd0, sel_idx};
            ID_ARM:  return {28'd0, armed_mask};
            ID_FLAG: return {31'd0, flag_alarm_armed};
            ID_RING: return {31'd0, ringing};
            ID_SNZ:  return {31'd0, snoozing};
            ID_RIDX: return {30'd0, ring_idx};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: drain every pending expectation on the falling edge.
    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] got;
        while (sb_q.size() > 0) begin
            c   = sb_q.pop_front();
            got = dut_val(c.id);
            tests++;
            if (got !== c.exp) begin
                fails++;
                $display("FAIL %s: got %0h expected %0h", c.name, got, c.exp);
            end
        end
    end

    task automatic expect_val(input int id, input logic [31:0] e, input string nm);
        chk_t c;
        c.id   = id;
        c.exp  = e;
        c.name = nm;
        sb_q.push_back(c);
    endtask

    task automatic check_now(input int id, input logic [31:0] e, input string nm);
        logic [31:0] got;
        got = dut_val(id);
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, e);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int b, input int n);
        for (int k = 0; k < n; k++) begin
            btn[b] = 1'b0;
            cyc(5);
            btn[b] = 1'b1;
            cyc(5);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            tick_1hz = 1'b1;
            cyc(1);
            tick_1hz = 1'b0;
            cyc(1);
        end
    endtask

    task automatic set_time(input logic [23:0] t);
        {hd_in, hu_in, md_in, mu_in, sd_in, su_in} = t;
    endtask

    initial begin
        set_time(24'h123456);
        cyc(3);
        reset = 1'b1;
        cyc(2);
        check_now(ID_DISP, 32'h000000, "reset_disp_now");
        check_now(ID_RING, 32'd0,      "reset_ringing_now");
        expect_val(ID_DISP, 32'h000000, "reset_disp");
        expect_val(ID_SEL,  32'd0,      "reset_sel");
        expect_val(ID_ARM,  32'd0,      "reset_armed");
        expect_val(ID_FLAG, 32'd0,      "reset_flag");
        expect_val(ID_RING, 32'd0,      "reset_ringing");
        expect_val(ID_SNZ,  32'd0,      "reset_snoozing");
        expect_val(ID_RIDX, 32'd0,      "reset_ring_idx");

        // Field editing on slot 2 with in-field carries only.
        press(3, 2);
        expect_val(ID_SEL, 32'd2, "sel_after_two_next");
        press(1, 1);
        press(0, 10);
        expect_val(ID_DISP, 32'h001000, "minutes_09_to_10");
        press(1, 1);
        press(0, 23);
        expect_val(ID_DISP, 32'h231000, "hours_23");
        press(0, 1);
        expect_val(ID_DISP, 32'h001000, "hours_wrap_00");
        press(1, 1);
        press(0, 59);
        expect_val(ID_DISP, 32'h001059, "seconds_59");
        press(0, 1);
        expect_val(ID_DISP, 32'h001000, "seconds_wrap_no_carry");

        // Slot 1 set to 07:30:00 and armed.
        press(3, 3);
        expect_val(ID_SEL, 32'd1, "sel_wrap_to_1");
        press(1, 1);
        press(0, 30);
        press(1, 1);
        press(0, 7);
        expect_val(ID_DISP, 32'h073000, "slot1_0730");
        press(2, 1);
        expect_val(ID_ARM,  32'b0010, "arm_slot1");
        expect_val(ID_FLAG, 32'd1,    "flag_armed");

        // Match -> ring, then auto-timeout after 60 ticks.
        set_time(24'h073000);
        cyc(2);
        expect_val(ID_RING, 32'd1, "ring_on_match");
        expect_val(ID_RIDX, 32'd1, "ring_idx_1");
        tick(59);
        expect_val(ID_RING, 32'd1, "still_ring_59");
        tick(1);
        check_now(ID_RING, 32'd0, "timeout_60_now");
        expect_val(ID_RING, 32'd0, "timeout_60");

        // Snooze for 300 ticks, re-ring, dismiss.
        set_time(24'h000000);
        cyc(2);
        set_time(24'h073000);
        cyc(2);
        expect_val(ID_RING, 32'd1, "reRing");
        press(0, 1);
        expect_val(ID_SNZ,  32'd1, "snooze_on");
        expect_val(ID_RING, 32'd0, "ring_off_in_snooze");
        tick(299);
        expect_val(ID_SNZ, 32'd1, "snooze_299");
        tick(1);
        expect_val(ID_RING, 32'd1, "ring_after_snooze");
        expect_val(ID_RIDX, 32'd1, "ring_idx_kept");
        press(3, 1);
        expect_val(ID_RING, 32'd0, "dismiss");
        expect_val(ID_SNZ,  32'd0, "dismiss_snz");
        expect_val(ID_ARM,  32'b0010, "armed_after_dismiss");
        expect_val(ID_SEL,  32'd1, "sel_kept_dismiss");

        // Edits are locked while ringing; disarm during snooze ends it.
        set_time(24'h000001);
        cyc(2);
        set_time(24'h073000);
        cyc(2);
        press(2, 1);
        expect_val(ID_ARM,  32'b0010, "no_disarm_ringing");
        expect_val(ID_RING, 32'd1,    "btn2_keeps_ring");
        press(0, 1);
        expect_val(ID_SNZ,  32'd1,        "snooze_again");
        expect_val(ID_DISP, 32'h073000,   "digits_unchanged");
        press(2, 1);
        expect_val(ID_SNZ,  32'd0, "disarm_ends_snooze");
        expect_val(ID_RING, 32'd0, "disarm_no_ring");
        expect_val(ID_ARM,  32'd0, "disarm_bit_cleared");

        // Slots 0 and 3 share 00:00:00: the lowest index wins.
        press(3, 2);
        press(2, 1);
        expect_val(ID_ARM, 32'b1000, "arm_slot3");
        press(3, 1);
        expect_val(ID_SEL, 32'd0, "sel_wrap_0");
        press(2, 1);
        expect_val(ID_ARM, 32'b1001, "arm_slot0");
        set_time(24'h000000);
        cyc(2);
        expect_val(ID_RING, 32'd1, "dual_ring");
        expect_val(ID_RIDX, 32'd0, "dual_lowest_idx");
        press(3, 1);
        cyc(10);
        expect_val(ID_RING, 32'd0, "no_retrigger");
        expect_val(ID_RIDX, 32'd0, "ring_idx_holds");

        // Reset in the middle of a snooze.
        set_time(24'h000001);
        cyc(2);
        set_time(24'h000000);
        cyc(2);
        press(0, 1);
        expect_val(ID_SNZ, 32'd1, "snooze_before_reset");
        cyc(1);
        reset = 1'b0;
        expect_val(ID_SNZ,  32'd0, "rst_snoozing");
        expect_val(ID_RING, 32'd0, "rst_ringing");
        expect_val(ID_ARM,  32'd0, "rst_armed");
        expect_val(ID_FLAG, 32'd0, "rst_flag");
        expect_val(ID_SEL,  32'd0, "rst_sel");
        @(negedge clk);
        #1;
        cyc(2);
        reset = 1'b1;
        cyc(2);

        // Blink on the selected seconds field.
        press(0, 5);
        expect_val(ID_DISP, 32'h000005, "blink_on_digits");
        clk_3hz = 1'b1;
        cyc(5);
        expect_val(ID_DISP, 32'h0000FF, "blink_off_blank");
        clk_3hz = 1'b0;
        cyc(5);
        expect_val(ID_DISP, 32'h0000FF, "fall_no_toggle");
        clk_3hz = 1'b1;
        cyc(5);
        expect_val(ID_DISP, 32'h000005, "blink_back_on");

        cyc(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multi_alarm.md
Name: multi_alarm

Overview:
Parametrised successor of the single-alarm block. Holds NUM_ALARMS independent BCD HH:MM:SS alarm slots, each with its own arm bit, and edits them with active-low push buttons and a 3 Hz blink on the selected field. It compares every armed slot against the clock's BCD time and runs a ring/snooze/dismiss state machine with auto-timeout driven by a 1 Hz tick. It sits between the clock core, the button inputs and the 7-segment display mux.

Parameters:
NUM_ALARMS, 4, number of alarm slots (1..16)
IDX_W, 2, width of slot index; must equal max(1, clog2(NUM_ALARMS))
RING_SECONDS, 60, seconds ringing lasts before auto-dismiss (1..255)
SNOOZE_MINUTES, 5, snooze length in minutes (1..59)

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
clk_3hz  in  1  free-running 3 Hz square wave, asynchronous to clk
tick_1hz  in  1  one-clk-cycle pulse per second, synchronous to clk
btn  in  4  active-low buttons: [0] increment or snooze, [1] next field, [2] toggle arm, [3] next slot or dismiss
horas_decenas_in, horas_unidades_in, minutos_decenas_in, minutos_unidades_in, segundos_decenas_in, segundos_unidades_in  in  4 each  current time, BCD
horas_decenas, horas_unidades, minutos_decenas, minutos_unidades, segundos_decenas, segundos_unidades  out  4 each  selected slot's time for display; 4'hF means blank
sel_idx  out  IDX_W  slot currently being edited
armed_mask  out  NUM_ALARMS  arm bit per slot
flag_alarm_armed  out  1  OR of armed_mask
ringing  out  1  high in RINGING
snoozing  out  1  high in SNOOZE
ring_idx  out  IDX_W  slot that triggered the current ring or snooze; holds its value when IDLE

Behaviour:
- Reset (reset low, asynchronous):
  - All slots 00:00:00, armed_mask 0, sel_idx 0, field = seconds.
  - blink 1, state IDLE, ring_idx 0, counters 0.
  - Button synchroniser flops 1; clk_3hz synchroniser flops 0.
  - Reset mid-ring or mid-snooze drops to IDLE immediately.
- Buttons: two-flop synchroniser. A press is a 1->0 edge on the synchronised signal: one clk pulse, 2-3 cycle latency. Holding a button has no further effect.
- Blink: clk_3hz goes through a two-flop synchroniser. Each rising edge toggles blink.
- Display: shows slot sel_idx as stored. The selected field pair (seconds, minutes or hours) reads 4'hF while blink == 0, in every state.
- Field select: btn1 cycles seconds -> minutes -> hours -> seconds. btn3 in IDLE advances sel_idx, wrapping NUM_ALARMS-1 -> 0, and resets the field to seconds.
- Increment (btn0, not in RINGING) on the selected field of slot sel_idx:
  - Seconds and minutes: BCD 00..59 wrap to 00; the units digit carries into the tens digit.
  - Hours: 00..23; 23 -> 00; x9 -> (x+1)0.
  - Carries stay inside the field and never ripple into the next field.
- btn2 (not in RINGING) toggles armed_mask[sel_idx].
- Match: match_vec[i] = armed_mask[i] AND all six BCD digits of slot i equal the current-time inputs. A rising edge of match_vec[i], registered previous value vs current, is a trigger.
- State IDLE:
  - Any trigger -> RINGING. ring_idx = lowest triggering index, ring counter cleared.
  - Simultaneous triggers on other slots are discarded.
- State RINGING:
  - ringing = 1. Buttons are consumed by the FSM and never edit slots.
  - btn0 -> SNOOZE, snooze counter = SNOOZE_MINUTES*60.
  - btn3 -> IDLE (dismiss).
  - Each tick_1hz increments the ring counter. When it reaches RING_SECONDS -> IDLE.
  - A button press in the same cycle as a tick takes priority over the timeout.
  - New triggers are ignored.
- State SNOOZE:
  - snoozing = 1.
  - Each tick_1hz decrements the snooze counter. On the tick where it reaches 0 -> RINGING with the same ring_idx and the ring counter cleared.
  - btn3 -> IDLE and cancels the snooze; sel_idx does not change.
  - btn0, btn1 and btn2 edit normally. If btn2 disarms slot ring_idx -> IDLE.
  - New triggers are ignored.
- Counter widths:
  - Ring counter: 8 bits.
  - Snooze counter: 12 bits, since 59*60 = 3540.
- Editing a slot so it equals the current time while armed produces a trigger on the next cycle. This is intended.

Test Plan:
- Reset, then press btn3 twice, btn1 twice and btn0 24 times -> sel_idx 2, slot 2 hours read 00 (wrapped from 23). Slot 2 seconds 59 + btn0 -> 00, minutes unchanged.
- Arm slot 1 at 07:30:00 and drive the time to 07:30:00 -> ringing rises within 2 cycles, ring_idx 1. With no buttons, after RING_SECONDS=60 ticks -> ringing 0, state IDLE.
- While ringing, press btn0 -> snoozing 1. After 300 ticks -> ringing 1 with the same ring_idx. Press btn3 -> IDLE, and armed_mask is unchanged.
- Arm slots 0 and 3 with the same time and let it match -> ring_idx 0; slot 3's trigger is dropped. Hold the time steady -> no retrigger after dismiss.
- During RINGING press btn2 and btn0 -> armed_mask and slot digits unchanged. During SNOOZE with sel_idx = ring_idx, press btn2 -> IDLE, bit cleared.
- Assert reset mid-SNOOZE -> all outputs at reset values within 0 clk edges. With clk_3hz toggling, the selected field alternates 4'hF and its digits at 3 Hz toggles.
